// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: sequences an external LFSR through a seed load or a
// timed roll, then draws a die face by rejection sampling of lfsr_q[3:0].
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; accepts a seed (priority) or a roll request
// LOAD  | lfsr_load high for this single cycle, then back to IDLE
// ROLL  | timed stepping: one lfsr_step every TICK_DIV cycles, ROLL_STEPS times
// DRAW  | rejection sampling of lfsr_q[3:0] against FACES, capped at 16 rejects
// DONE  | publishes result_valid and bumps roll_count, then back to IDLE
module dice_roll_ctrl #(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 50000,
    parameter int ROLL_STEPS = 16,
    parameter int FACES      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed,
    output logic             seed_ready,
    input  logic             roll_req,
    output logic             busy,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_step,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic [3:0]       result,
    output logic             result_valid,
    output logic [7:0]       roll_count
);

    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [7:0]        STEP_LAST = 8'(ROLL_STEPS - 1);
    localparam logic [4:0]        FACES_CMP = 5'(FACES);
    localparam logic [3:0]        FACE_MAX  = 4'(FACES);
    localparam logic [WIDTH-1:0]  SEED_ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROLL,
        DRAW,
        DONE
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [7:0]          steps_left;
    logic [3:0]          rej_cnt;
    logic [3:0]          cand;
    logic                unused_lfsr_hi;

    assign cand           = lfsr_q[3:0];
    assign unused_lfsr_hi = ^lfsr_q;

    // Sequencer: state, timers and all registered outputs.
    // The tick timer is a down-counter; lfsr_step is registered one cycle
    // ahead (at count 1) so it is high exactly in the terminal-count cycle.
    // In DRAW a cycle with lfsr_step high is a settle cycle: the LFSR only
    // advances at the end of it, so lfsr_q is re-evaluated the cycle after.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            steps_left   <= '0;
            rej_cnt      <= '0;
            busy         <= 1'b0;
            seed_ready   <= 1'b1;
            lfsr_load    <= 1'b0;
            lfsr_step    <= 1'b0;
            lfsr_seed    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            roll_count   <= '0;
        end else begin
            lfsr_load <= 1'b0;
            lfsr_step <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        // a zero seed would lock the LFSR, so substitute 1
                        lfsr_seed  <= (seed == '0) ? SEED_ONE : seed;
                        lfsr_load  <= 1'b1;
                        state      <= LOAD;
                        busy       <= 1'b1;
                        seed_ready <= 1'b0;
                    end else if (roll_req) begin
                        state        <= ROLL;
                        busy         <= 1'b1;
                        seed_ready   <= 1'b0;
                        result_valid <= 1'b0;
                        tick_cnt     <= TICK_LAST;
                        steps_left   <= STEP_LAST;
                        rej_cnt      <= '0;
                    end
                end
                LOAD: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    seed_ready <= 1'b1;
                end
                ROLL: begin
                    if (tick_cnt == '0) begin
                        tick_cnt <= TICK_LAST;
                        if (steps_left == '0) begin
                            state <= DRAW;
                        end else begin
                            steps_left <= steps_left - 8'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - TICK_ONE;
                        if (tick_cnt == TICK_ONE) begin
                            lfsr_step <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (!lfsr_step) begin
                        if ({1'b0, cand} < FACES_CMP) begin
                            result <= cand + 4'd1;
                            state  <= DONE;
                        end else if (rej_cnt == 4'd15) begin
                            // sixteenth consecutive reject: cap without stepping
                            result <= FACE_MAX;
                            state  <= DONE;
                        end else begin
                            rej_cnt   <= rej_cnt + 4'd1;
                            lfsr_step <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    result_valid <= 1'b1;
                    roll_count   <= roll_count + 8'd1;
                    state        <= IDLE;
                    busy         <= 1'b0;
                    seed_ready   <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    seed_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with TICK_DIV=4, ROLL_STEPS=3, FACES=6.
// The LFSR is modelled here: each step takes the next scripted value, or an
// 8-bit shift-LFSR update when the script is empty.
module tb_dice_roll_ctrl;

    localparam int WIDTH      = 8;
    localparam int TICK_DIV   = 4;
    localparam int ROLL_STEPS = 3;
    localparam int FACES      = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             seed_valid = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic             seed_ready;
    logic             roll_req = 1'b0;
    logic             busy;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_seed;
    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_q = 8'h00;
    logic [3:0]       result;
    logic             result_valid;
    logic [7:0]       roll_count;

    int errors = 0;
    int checks = 0;
    int step_total = 0;
    int load_total = 0;
    int overlap_total = 0;
    time step_times[$];
    logic [7:0] script[$];

    dice_roll_ctrl #(
        .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .ROLL_STEPS(ROLL_STEPS), .FACES(FACES)
    ) dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready), .roll_req(roll_req), .busy(busy),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
        .lfsr_q(lfsr_q), .result(result), .result_valid(result_valid),
        .roll_count(roll_count)
    );

    always #5 clk = ~clk;

    // external LFSR model plus strobe bookkeeping
    always @(posedge clk) begin
        if (lfsr_load && lfsr_step) overlap_total <= overlap_total + 1;
        if (lfsr_load) begin
            lfsr_q     <= lfsr_seed;
            load_total <= load_total + 1;
        end else if (lfsr_step) begin
            step_total <= step_total + 1;
            step_times.push_back($time);
            if (script.size() > 0) lfsr_q <= script.pop_front();
            else lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL reset_seed_ready: got %b want 1", seed_ready); end
        checks++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", lfsr_load); end
        checks++; if (lfsr_step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", lfsr_step); end
        checks++; if (lfsr_seed !== 8'h00) begin errors++; $display("FAIL reset_lfsr_seed: got %h want 00", lfsr_seed); end
        checks++; if (result !== 4'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
        checks++; if (roll_count !== 8'd0) begin errors++; $display("FAIL reset_roll_count: got %0d want 0", roll_count); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL post_reset_seed_ready: got %b want 1", seed_ready); end
    endtask

    task automatic test_seed_zero();
        int l0;
        l0 = load_total;
        seed_valid = 1'b1; seed = 8'h00;
        @(negedge clk);
        seed_valid = 1'b0;
        checks++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL seed0_load: got %b want 1", lfsr_load); end
        checks++; if (lfsr_seed !== 8'h01) begin errors++; $display("FAIL seed0_value: got %h want 01", lfsr_seed); end
        checks++; if (busy !== 1'b1 || seed_ready !== 1'b0) begin errors++; $display("FAIL seed0_busy: got busy=%b ready=%b want 1/0", busy, seed_ready); end
        @(negedge clk);
        checks++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL seed0_load_len: got %b want 0", lfsr_load); end
        checks++; if (busy !== 1'b0 || seed_ready !== 1'b1) begin errors++; $display("FAIL seed0_idle: got busy=%b ready=%b want 0/1", busy, seed_ready); end
        checks++; if (lfsr_q !== 8'h01) begin errors++; $display("FAIL seed0_lfsr: got %h want 01", lfsr_q); end
        checks++; if (load_total - l0 !== 1) begin errors++; $display("FAIL seed0_load_count: got %0d want 1", load_total - l0); end
    endtask

    task automatic test_collision();
        int l0, s0;
        l0 = load_total; s0 = step_total;
        seed_valid = 1'b1; seed = 8'h5A; roll_req = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0; roll_req = 1'b0;
        checks++; if (lfsr_load !== 1'b1 || lfsr_seed !== 8'h5A) begin errors++; $display("FAIL coll_load: got load=%b seed=%h want 1/5a", lfsr_load, lfsr_seed); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || lfsr_load !== 1'b0) begin errors++; $display("FAIL coll_idle: got busy=%b load=%b want 0/0", busy, lfsr_load); end
        repeat (8) @(negedge clk);
        checks++; if (step_total - s0 !== 0) begin errors++; $display("FAIL coll_steps: got %0d want 0", step_total - s0); end
        checks++; if (roll_count !== 8'd0) begin errors++; $display("FAIL coll_roll_count: got %0d want 0", roll_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b want 0", busy); end
        checks++; if (load_total - l0 !== 1) begin errors++; $display("FAIL coll_loads: got %0d want 1", load_total - l0); end
    endtask

    task automatic test_normal_roll();
        time t0;
        int n;
        time exp_t[4];
        exp_t = '{40, 80, 120, 140};
        script = '{8'h31, 8'h42, 8'h0A, 8'h23};
        step_times.delete();
        roll_req = 1'b1;
        t0 = $time + 5;
        @(negedge clk);
        roll_req = 1'b0;
        checks++; if (busy !== 1'b1 || seed_ready !== 1'b0) begin errors++; $display("FAIL roll_busy: got busy=%b ready=%b want 1/0", busy, seed_ready); end
        n = 0;
        while (!result_valid && n < 60) begin @(negedge clk); n++; end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL roll_timeout: got valid=%b want 1", result_valid); end
        checks++; if ($time - t0 !== 165) begin errors++; $display("FAIL roll_latency: got %0t want 165 after entry", $time - t0); end
        checks++; if (result !== 4'd4) begin errors++; $display("FAIL roll_result: got %0d want 4", result); end
        checks++; if (roll_count !== 8'd1) begin errors++; $display("FAIL roll_count1: got %0d want 1", roll_count); end
        checks++; if (busy !== 1'b0 || seed_ready !== 1'b1) begin errors++; $display("FAIL roll_idle: got busy=%b ready=%b want 0/1", busy, seed_ready); end
        checks++; if (lfsr_q !== 8'h23) begin errors++; $display("FAIL roll_lfsr: got %h want 23", lfsr_q); end
        checks++; if (step_times.size() !== 4) begin errors++; $display("FAIL roll_step_count: got %0d want 4", step_times.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (step_times[i] - t0 !== exp_t[i]) begin
                    errors++; $display("FAIL roll_step_time%0d: got %0t want %0t", i, step_times[i] - t0, exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_reject_cap();
        time t0;
        int n, s0;
        script.delete();
        for (int i = 0; i < 18; i++) script.push_back(8'hFF);
        s0 = step_total;
        roll_req = 1'b1;
        t0 = $time + 5;
        @(negedge clk);
        roll_req = 1'b0;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL cap_valid_clear: got %b want 0", result_valid); end
        checks++; if (result !== 4'd4) begin errors++; $display("FAIL cap_result_kept: got %0d want 4", result); end
        n = 0;
        while (!result_valid && n < 120) begin @(negedge clk); n++; end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL cap_timeout: got valid=%b want 1", result_valid); end
        checks++; if ($time - t0 !== 445) begin errors++; $display("FAIL cap_latency: got %0t want 445 after entry", $time - t0); end
        checks++; if (result !== 4'd6) begin errors++; $display("FAIL cap_result: got %0d want 6", result); end
        checks++; if (step_total - s0 !== 18) begin errors++; $display("FAIL cap_steps: got %0d want 18 (3 roll + 15 draw)", step_total - s0); end
        checks++; if (roll_count !== 8'd2) begin errors++; $display("FAIL cap_roll_count: got %0d want 2", roll_count); end
    endtask

    task automatic test_ignore_while_busy();
        int n, s0, l0;
        script = '{8'h10, 8'h20, 8'h05};
        s0 = step_total; l0 = load_total;
        roll_req = 1'b1;
        @(negedge clk);
        seed_valid = 1'b1; seed = 8'h77;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1 || seed_ready !== 1'b0) begin errors++; $display("FAIL busy_hold: got busy=%b ready=%b want 1/0", busy, seed_ready); end
        seed_valid = 1'b0; roll_req = 1'b0;
        n = 0;
        while (!result_valid && n < 60) begin @(negedge clk); n++; end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL busy_timeout: got valid=%b want 1", result_valid); end
        checks++; if (result !== 4'd6) begin errors++; $display("FAIL busy_result: got %0d want 6", result); end
        checks++; if (load_total - l0 !== 0) begin errors++; $display("FAIL busy_loads: got %0d want 0", load_total - l0); end
        checks++; if (lfsr_seed !== 8'h5A) begin errors++; $display("FAIL busy_seed: got %h want 5a", lfsr_seed); end
        checks++; if (step_total - s0 !== 3) begin errors++; $display("FAIL busy_steps: got %0d want 3", step_total - s0); end
        checks++; if (roll_count !== 8'd3) begin errors++; $display("FAIL busy_roll_count: got %0d want 3", roll_count); end
    endtask

    task automatic test_mid_reset();
        int n, s0, l0;
        script = '{8'h61, 8'h62, 8'h63, 8'h64};
        s0 = step_total; l0 = load_total;
        roll_req = 1'b1;
        @(negedge clk);
        roll_req = 1'b0;
        n = 0;
        while (step_total - s0 < 2 && n < 40) begin @(negedge clk); n++; end
        checks++; if (step_total - s0 !== 2) begin errors++; $display("FAIL mid_two_ticks: got %0d want 2", step_total - s0); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || seed_ready !== 1'b1) begin errors++; $display("FAIL mid_busy: got busy=%b ready=%b want 0/1", busy, seed_ready); end
        checks++; if (result_valid !== 1'b0 || result !== 4'd0) begin errors++; $display("FAIL mid_result: got valid=%b result=%0d want 0/0", result_valid, result); end
        checks++; if (roll_count !== 8'd0) begin errors++; $display("FAIL mid_roll_count: got %0d want 0", roll_count); end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (step_total - s0 !== 2) begin errors++; $display("FAIL mid_no_step: got %0d want 2", step_total - s0); end
        checks++; if (load_total - l0 !== 0) begin errors++; $display("FAIL mid_no_load: got %0d want 0", load_total - l0); end
        checks++; if (lfsr_q !== 8'h62) begin errors++; $display("FAIL mid_lfsr_kept: got %h want 62", lfsr_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_seed_zero();
        test_collision();
        test_normal_roll();
        test_reject_cap();
        test_ignore_while_busy();
        test_mid_reset();
        checks++; if (overlap_total !== 0) begin errors++; $display("FAIL load_step_overlap: got %0d want 0", overlap_total); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
